// File: rtl/bus_master_if_pkg.sv
// ============================================================================
// bus_master_if_pkg : shared bus definitions and master-interface state codes
// Rev 1.0
// ============================================================================
`default_nettype none

package bus_master_if_pkg;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    localparam int WORD_ADDR_W    = 30;
    localparam int WORD_DATA_W    = 32;
    localparam int BUS_IF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        BUS_IF_STATE_IDLE   = 2'd0,
        BUS_IF_STATE_REQ    = 2'd1,
        BUS_IF_STATE_ACCESS = 2'd2,
        BUS_IF_STATE_STALL  = 2'd3
    } BusIfStateBus;

endpackage

`default_nettype wire

// File: rtl/bus_timeout_cnt.sv
// ============================================================================
// bus_timeout_cnt : clearable up-counter with terminal-count compare
// Rev 1.0
// ============================================================================
`default_nettype none

module bus_timeout_cnt #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [CNT_W-1:0] C_TC = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == C_TC);

endmodule

`default_nettype wire

// File: rtl/bus_master_if.sv
// ============================================================================
// bus_master_if : CPU access to shared-bus request/grant/strobe/ready handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module bus_master_if
    import bus_master_if_pkg::*;
#(
    parameter int TIMEOUT = BUS_IF_TIMEOUT,
    parameter int CNT_W   = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_stall,
    input  logic                   i_flush,
    output logic                   o_busy,
    input  logic [WORD_ADDR_W-1:0] i_addr,
    input  logic                   i_as_,
    input  logic                   i_rw,
    input  logic [WORD_DATA_W-1:0] i_wr_data,
    output logic [WORD_DATA_W-1:0] o_rd_data,
    output logic                   o_bus_err,
    input  logic [WORD_DATA_W-1:0] i_bus_rd_data,
    input  logic                   i_bus_rdy_,
    input  logic                   i_bus_grnt_,
    output logic                   o_bus_req_,
    output logic [WORD_ADDR_W-1:0] o_bus_addr,
    output logic                   o_bus_as_,
    output logic                   o_bus_rw,
    output logic [WORD_DATA_W-1:0] o_bus_wr_data
);

    BusIfStateBus           r_state;
    logic                   r_bus_req_;
    logic                   r_bus_as_;
    logic [WORD_ADDR_W-1:0] r_bus_addr;
    logic                   r_bus_rw;
    logic [WORD_DATA_W-1:0] r_bus_wr_data;
    logic [WORD_DATA_W-1:0] r_rd_buf;
    logic                   r_bus_err;

    BusIfStateBus           w_state_nx;
    logic                   w_bus_req_nx;
    logic                   w_bus_as_nx;
    logic [WORD_ADDR_W-1:0] w_bus_addr_nx;
    logic                   w_bus_rw_nx;
    logic [WORD_DATA_W-1:0] w_bus_wr_data_nx;
    logic [WORD_DATA_W-1:0] w_rd_buf_nx;
    logic                   w_bus_err_nx;
    logic                   w_busy;
    logic [WORD_DATA_W-1:0] w_rd_data;
    logic                   w_cnt_clr;
    logic                   w_cnt_en;
    logic                   w_tc;

    assign w_cnt_en = (r_state == BUS_IF_STATE_ACCESS);

    bus_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_cnt_clr),
        .i_en  (w_cnt_en),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= BUS_IF_STATE_IDLE;
            r_bus_req_    <= DISABLE_;
            r_bus_as_     <= DISABLE_;
            r_bus_addr    <= '0;
            r_bus_rw      <= READ;
            r_bus_wr_data <= '0;
            r_rd_buf      <= '0;
            r_bus_err     <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_bus_req_    <= w_bus_req_nx;
            r_bus_as_     <= w_bus_as_nx;
            r_bus_addr    <= w_bus_addr_nx;
            r_bus_rw      <= w_bus_rw_nx;
            r_bus_wr_data <= w_bus_wr_data_nx;
            r_rd_buf      <= w_rd_buf_nx;
            r_bus_err     <= w_bus_err_nx;
        end
    end

    always_comb begin
        w_state_nx       = r_state;
        w_bus_req_nx     = r_bus_req_;
        w_bus_as_nx      = r_bus_as_;
        w_bus_addr_nx    = r_bus_addr;
        w_bus_rw_nx      = r_bus_rw;
        w_bus_wr_data_nx = r_bus_wr_data;
        w_rd_buf_nx      = r_rd_buf;
        w_bus_err_nx     = 1'b0;
        w_busy           = 1'b0;
        w_rd_data        = r_rd_buf;
        w_cnt_clr        = 1'b0;

        case (r_state)
            BUS_IF_STATE_IDLE: begin
                if (!i_flush && (i_as_ == ENABLE_)) begin
                    w_bus_addr_nx    = i_addr;
                    w_bus_rw_nx      = i_rw;
                    w_bus_wr_data_nx = i_wr_data;
                    w_bus_req_nx     = ENABLE_;
                    w_busy           = 1'b1;
                    w_state_nx       = BUS_IF_STATE_REQ;
                end
            end
            BUS_IF_STATE_REQ: begin
                w_busy = 1'b1;
                if (i_bus_grnt_ == ENABLE_) begin
                    w_bus_as_nx = ENABLE_;
                    w_cnt_clr   = 1'b1;
                    w_state_nx  = BUS_IF_STATE_ACCESS;
                end
            end
            BUS_IF_STATE_ACCESS: begin
                w_bus_as_nx = DISABLE_;
                w_rd_data   = '0;
                // Ready is checked first so a late ready on the last cycle still completes.
                if ((i_bus_rdy_ == ENABLE_) || w_tc) begin
                    w_bus_req_nx     = DISABLE_;
                    w_bus_addr_nx    = '0;
                    w_bus_rw_nx      = READ;
                    w_bus_wr_data_nx = '0;
                    w_state_nx       = i_stall ? BUS_IF_STATE_STALL : BUS_IF_STATE_IDLE;
                    if (i_bus_rdy_ == ENABLE_) begin
                        w_rd_data = i_bus_rd_data;
                        if (r_bus_rw == READ) begin
                            w_rd_buf_nx = i_bus_rd_data;
                        end
                    end else begin
                        w_rd_buf_nx  = '0;
                        w_bus_err_nx = 1'b1;
                    end
                end else begin
                    w_busy = 1'b1;
                end
            end
            BUS_IF_STATE_STALL: begin
                if (!i_stall) begin
                    w_state_nx = BUS_IF_STATE_IDLE;
                end
            end
            default: begin
                w_state_nx = BUS_IF_STATE_IDLE;
            end
        endcase
    end

    assign o_busy        = w_busy;
    assign o_rd_data     = w_rd_data;
    assign o_bus_err     = r_bus_err;
    assign o_bus_req_    = r_bus_req_;
    assign o_bus_addr    = r_bus_addr;
    assign o_bus_as_     = r_bus_as_;
    assign o_bus_rw      = r_bus_rw;
    assign o_bus_wr_data = r_bus_wr_data;

endmodule

`default_nettype wire
